seq_mul32_unit: RTL and testbench

//   Iterative 32x32 unsigned shift-and-add multiplier for the RV32 execute stage.

---
 rtl/seq_mul32_unit_pkg.sv | 33 +++
 rtl/seq_mul32_unit_cla.sv | 45 ++++
 rtl/seq_mul32_unit.sv | 122 ++++++++++++
 tb/tb_seq_mul32_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mul32_unit_pkg.sv
// Shared types and constants for the iterative 32x32 multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_mul32_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  // Index of the final shift-and-add step (32 steps total: 0..31).
  localparam logic [CNT_W-1:0] STEP_LAST = 5'd31;

  // Result word selection.
  localparam logic OP_MUL   = 1'b0;  // low word of the product
  localparam logic OP_MULHU = 1'b1;  // high word of the product

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Pick the requested 32-bit word out of a 64-bit product.
  function automatic logic [XLEN-1:0] sel_word(input logic op, input logic [2*XLEN-1:0] prod);
    logic [XLEN-1:0] w;
    case (op)
      OP_MUL:   w = prod[XLEN-1:0];
      OP_MULHU: w = prod[2*XLEN-1:XLEN];
      default:  w = prod[XLEN-1:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/seq_mul32_unit_cla.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups chained by group generate/propagate.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_a, i_b (addends), i_cin (carry in), o_sum (32-bit sum), o_cout (carry out).
module seq_mul32_unit_cla
  import seq_mul32_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_cin,
  output logic [XLEN-1:0] o_sum,
  output logic            o_cout
);

  logic [XLEN-1:0]   w_g;   // bit generate
  logic [XLEN-1:0]   w_p;   // bit propagate (xor form, reused for the sum)
  logic [XLEN-1:0]   w_c;   // carry into each bit
  logic [XLEN/4:0]   w_gc;  // carry into each 4-bit group

  always_comb begin
    w_g     = i_a & i_b;
    w_p     = i_a ^ i_b;
    w_c     = '0;
    w_gc    = '0;
    w_gc[0] = i_cin;
    for (int k = 0; k < XLEN/4; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      // Group carry-out from group generate / group propagate.
      w_gc[k+1]  = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
  end

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_gc[XLEN/4];

endmodule

// File: rtl/seq_mul32_unit.sv
// Iterative 32x32 unsigned shift-and-add multiplier returning MUL (low) or MULHU (high) word.
// Latency: 33 cycles accept-to-result (1 cycle when an operand is zero and ZERO_BYPASS=1).
// Backpressure: in_ready only in IDLE; result held in DONE with out_valid until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, A, B, op_hi on the request side;
//        out_valid/out_ready, S (selected product word) on the result side.
module seq_mul32_unit
  import seq_mul32_unit_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        op_hi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] S
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;     // {acc_hi, acc_lo}; acc_lo starts as the multiplier
  logic [XLEN-1:0]     r_mcand;
  logic                r_op;
  logic [XLEN-1:0]     r_s;

  logic                w_run;
  logic                w_last;
  logic                w_accept;
  logic                w_zero_hit;
  logic [XLEN-1:0]     w_add_a;
  logic [XLEN-1:0]     w_add_b;
  logic [XLEN-1:0]     w_sum;
  logic                w_cout;
  logic [2*XLEN-1:0]   w_acc_nxt;

  assign w_run      = (r_state == ST_RUN);
  assign w_last     = w_run && (r_cnt == STEP_LAST);
  assign w_accept   = (r_state == ST_IDLE) && in_valid;
  assign w_zero_hit = ZERO_BYPASS && ((A == '0) || (B == '0));

  // Adder inputs are parked at zero outside RUN.
  assign w_add_a = w_run ? r_acc[2*XLEN-1:XLEN] : '0;
  assign w_add_b = (w_run && r_acc[0]) ? r_mcand : '0;

  seq_mul32_unit_cla u_cla_32bit (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The adder carry lands in acc[63] so the 64-bit product stays exact;
  // the consumed multiplier bit falls off the bottom.
  assign w_acc_nxt = {w_cout, w_sum, r_acc[XLEN-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero_hit ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_op    <= OP_MUL;
      r_s     <= '0;
    end else begin
      if (w_accept) begin
        r_mcand <= A;
        r_acc   <= {{XLEN{1'b0}}, B};
        r_cnt   <= '0;
        r_op    <= op_hi;
        if (w_zero_hit) begin
          r_s <= '0;
        end
      end else if (w_run) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_s <= sel_word(r_op, w_acc_nxt);
        end
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign S         = r_s;

endmodule

// File: tb/tb_seq_mul32_unit.sv
// Directed and randomized checks of seq_mul32_unit (bypass and non-bypass builds).
// Latency: n/a.
// Backpressure: exercises held results and ignored requests while busy.
module tb_seq_mul32_unit;

  logic        clk;
  logic        rst;
  // DUT with zero bypass enabled
  logic        in_valid, in_ready, op_hi, out_valid, out_ready;
  logic [31:0] a_in, b_in, s_out;
  // DUT with zero bypass disabled
  logic        z_in_valid, z_in_ready, z_op_hi, z_out_valid, z_out_ready;
  logic [31:0] z_a_in, z_b_in, z_s_out;

  int n_checks;
  int n_errors;

  seq_mul32_unit #(.ZERO_BYPASS(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .op_hi     (op_hi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (s_out)
  );

  seq_mul32_unit #(.ZERO_BYPASS(1'b0)) u_dut_nb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (z_in_valid),
    .in_ready  (z_in_ready),
    .A         (z_a_in),
    .B         (z_b_in),
    .op_hi     (z_op_hi),
    .out_valid (z_out_valid),
    .out_ready (z_out_ready),
    .S         (z_s_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle; returns at a negedge after the
  // result handshake, so a following call issues its request in the very next cycle.
  task automatic run_op(input string tag, input bit nb, input logic [31:0] a,
                        input logic [31:0] b, input logic hi, input int exp_lat,
                        input logic [31:0] exp_s);
    int lat;
    chk({tag, "_in_ready"}, {63'd0, (nb ? z_in_ready : in_ready)}, 64'd1);
    if (nb) begin
      z_in_valid = 1'b1; z_a_in = a; z_b_in = b; z_op_hi = hi;
    end else begin
      in_valid = 1'b1; a_in = a; b_in = b; op_hi = hi;
    end
    @(negedge clk);  // accepted at the edge just passed; now in cycle 1
    in_valid = 1'b0;
    z_in_valid = 1'b0;
    // Scramble operands after accept: must not affect the result.
    a_in = $urandom; b_in = $urandom; op_hi = ~hi;
    z_a_in = $urandom; z_b_in = $urandom; z_op_hi = ~hi;
    lat = 1;
    while (!(nb ? z_out_valid : out_valid) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_S"}, {32'd0, (nb ? z_s_out : s_out)}, {32'd0, exp_s});
    out_ready = 1'b1;
    z_out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    z_out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int extra;
    logic [31:0] ra, rb;
    logic        rh;
    logic [63:0] prod;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    // Request held during reset must not be accepted (reset wins).
    in_valid = 1'b1; a_in = 32'd1; b_in = 32'd1; op_hi = 1'b0; out_ready = 1'b1;
    z_in_valid = 1'b1; z_a_in = 32'd1; z_b_in = 32'd1; z_op_hi = 1'b0; z_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_S", {32'd0, s_out}, 64'd0);
    chk("rst_nb_in_ready", {63'd0, z_in_ready}, 64'd1);
    chk("rst_nb_out_valid", {63'd0, z_out_valid}, 64'd0);
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    z_in_valid = 1'b0; z_out_ready = 1'b0;
    @(negedge clk);

    // T1: small operands, both words
    run_op("t1_lo", 1'b0, 32'd3, 32'd5, 1'b0, 33, 32'h0000000F);
    run_op("t1_hi", 1'b0, 32'd3, 32'd5, 1'b1, 33, 32'h00000000);

    // T2: all-ones squared: 0xFFFFFFFE_00000001
    run_op("t2_lo", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, 32'h00000001);
    run_op("t2_hi", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33, 32'hFFFFFFFE);

    // T3: zero operand, with and without bypass
    run_op("t3_byp_a0", 1'b0, 32'd0, 32'h1234, 1'b0, 1, 32'd0);
    run_op("t3_byp_b0", 1'b0, 32'hDEADBEEF, 32'd0, 1'b1, 1, 32'd0);
    run_op("t3_nb_a0", 1'b1, 32'd0, 32'h1234, 1'b0, 33, 32'd0);

    // T4: 0x80000000*2 = 0x1_00000000, with busy-time requests and held result
    in_valid = 1'b1; a_in = 32'h80000000; b_in = 32'd2; op_hi = 1'b1;
    @(negedge clk);
    a_in = 32'd5; b_in = 32'd5; op_hi = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("t4_in_ready_run", {63'd0, in_ready}, 64'd0);
      in_valid = lat[0];
      @(negedge clk);
      lat++;
    end
    chk("t4_latency", 64'(lat), 64'd33);
    chk("t4_S", {32'd0, s_out}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      @(negedge clk);
      chk("t4_hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("t4_hold_S", {32'd0, s_out}, 64'd1);
      chk("t4_hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4_after_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t4_after_in_ready", {63'd0, in_ready}, 64'd1);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("t4_no_extra_result", 64'(extra), 64'd0);

    // T5: reset while at RUN step 16, then a fresh operation
    in_valid = 1'b1; a_in = 32'h12345678; b_in = 32'h9ABCDEF0; op_hi = 1'b0;
    @(negedge clk);  // cycle 1, step 0
    in_valid = 1'b0;
    repeat (16) @(negedge clk);  // cycle 17, step 16
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_rst_in_ready", {63'd0, in_ready}, 64'd1);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("t5_no_result", 64'(extra), 64'd0);
    run_op("t5_7x6", 1'b0, 32'd7, 32'd6, 1'b0, 33, 32'd42);

    // T6: back-to-back random operations against a 64-bit reference product
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rh = 1'($urandom_range(1, 0));
      if (i % 97 == 5) ra = 32'd0;
      if (i % 89 == 7) rb = 32'd0;
      prod = 64'(ra) * 64'(rb);
      run_op("t6_rand", 1'b0, ra, rb, rh, ((ra == 0) || (rb == 0)) ? 1 : 33,
             rh ? prod[63:32] : prod[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
